// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep harness and its downstream stages.
package tt_pkg;

    localparam int N_IN_DEF  = 7;
    localparam int TT_W_DEF  = 128;
    localparam int CNT_W_DEF = 8;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        RESULT
    } tt_state_t;

    // Result record handed to classification/logging stages
    typedef struct packed {
        logic [TT_W_DEF-1:0]  tt;
        logic [CNT_W_DEF-1:0] onset;
    } tt_result_t;

endpackage

// File: rtl/tt_settle_cnt.sv
// Settle timer: cleared by load, counts while enabled, flags the last settle cycle.
module tt_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt;

    // Count settle cycles of the current pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // Expire on the final settle cycle while counting
    always_comb begin
        expire = en && (cnt == W'(SETTLE - 1));
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all input patterns through an external combinational network and
// captures its truth table and onset count behind a valid/ready handshake.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 1,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int TT_W  = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [N_IN-1:0]   x_drv,
    input  logic              f_in,
    output logic [TT_W-1:0]   tt,
    output logic [CNT_W-1:0]  onset,
    output logic              tt_valid,
    input  logic              tt_ready
);

    tt_state_t       state_q, state_d;
    logic [N_IN-1:0] idx;
    logic            settle_load;
    logic            settle_en;
    logic            settle_expire;
    logic            begin_sweep;
    logic            sample;
    logic            handshake;

    tt_settle_cnt #(
        .SETTLE(SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .load   (settle_load),
        .en     (settle_en),
        .expire (settle_expire)
    );

    assign x_drv     = idx;
    assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
    assign handshake = tt_valid && tt_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and sweep control strobes
    always_comb begin
        state_d     = state_q;
        settle_load = 1'b1;
        settle_en   = 1'b0;
        begin_sweep = 1'b0;
        sample      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    begin_sweep = 1'b1;
                    state_d     = APPLY;
                end
            end
            APPLY: begin
                settle_load = 1'b0;
                settle_en   = 1'b1;
                if (settle_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                sample  = 1'b1;
                state_d = (&idx) ? RESULT : APPLY;
            end
            RESULT: begin
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pattern index, truth-table capture and result-valid flag.
    // tt_valid is registered, so it rises one cycle after RESULT is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            tt       <= '0;
            onset    <= '0;
            tt_valid <= 1'b0;
        end else begin
            tt_valid <= (state_q == RESULT) && !handshake;
            if (begin_sweep) begin
                idx   <= '0;
                tt    <= '0;
                onset <= '0;
            end else if (sample) begin
                tt[idx] <= f_in;
                onset   <= onset + CNT_W'(f_in);
                if (!(&idx)) begin
                    idx <= idx + N_IN'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench for tt_sweep_capture: directed sweeps plus a random
// truth table, with expectations built from a pattern-level function model.
module tb_tt_sweep_capture;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // Instance with SETTLE=1 (sel 0) and with SETTLE=3 (sel 1)
    logic         start1, start3, ready1, ready3;
    logic         busy1, busy3, valid1, valid3, f1, f3;
    logic [6:0]   x1, x3;
    logic [127:0] tt1, tt3;
    logic [7:0]   on1, on3;

    int           sel    = 0;
    int           mode   = 0;
    logic         start_g = 1'b0;
    logic         ready_g = 1'b0;
    logic [127:0] golden = 128'hfeeaeaaaeaaaaaa8eaaaaaa8aaa8a880;
    logic [127:0] rnd    = '0;

    logic         c_busy, c_valid;
    logic [6:0]   c_x;
    logic [127:0] c_tt;
    logic [7:0]   c_on;

    int           checks = 0;
    int           errors = 0;

    tt_sweep_capture #(.N_IN(7), .SETTLE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .x_drv(x1),
        .f_in(f1), .tt(tt1), .onset(on1), .tt_valid(valid1), .tt_ready(ready1)
    );

    tt_sweep_capture #(.N_IN(7), .SETTLE(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .x_drv(x3),
        .f_in(f3), .tt(tt3), .onset(on3), .tt_valid(valid3), .tt_ready(ready3)
    );

    always #5 clk = ~clk;

    // Network function under each test mode
    function automatic logic model_f(input int m, input logic [6:0] p);
        case (m)
            0:       return 1'b0;
            1:       return p[0];
            2:       return golden[p];
            3:       return 1'b1;
            4:       return p[6];
            default: return rnd[p];
        endcase
    endfunction

    function automatic logic [127:0] model_tt(input int m);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = model_f(m, 7'(i));
        return r;
    endfunction

    function automatic int model_onset(input int m);
        int n = 0;
        for (int i = 0; i < 128; i++) n += int'(model_f(m, 7'(i)));
        return n;
    endfunction

    // Network outputs and routing of the selected instance
    always_comb begin
        f1      = model_f(mode, x1);
        f3      = model_f(mode, x3);
        start1  = start_g && (sel == 0);
        start3  = start_g && (sel == 1);
        ready1  = ready_g && (sel == 0);
        ready3  = ready_g && (sel == 1);
        c_busy  = (sel == 1) ? busy3  : busy1;
        c_valid = (sel == 1) ? valid3 : valid1;
        c_x     = (sel == 1) ? x3     : x1;
        c_tt    = (sel == 1) ? tt3    : tt1;
        c_on    = (sel == 1) ? on3    : on1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep and follow it to tt_valid, checking pattern sequence,
    // busy window, latency and captured result.
    task automatic run_sweep(input string tag, input int s, input int m);
        int lat, bad_x, bad_b;
        int expx;
        mode    = m;
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        lat   = 0;
        bad_x = (c_x !== 7'd0) ? 1 : 0;
        bad_b = (c_busy !== 1'b1) ? 1 : 0;
        while (c_valid !== 1'b1 && lat < 2000) begin
            tick();
            lat++;
            expx = lat / (s + 1);
            if (expx > 127) expx = 127;
            if (c_x !== 7'(expx)) bad_x++;
            if (c_busy !== ((lat < 128 * (s + 1)) ? 1'b1 : 1'b0)) bad_b++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(1 + 128 * (s + 1)));
        chk({tag, "_xseq"}, 128'(bad_x), 128'd0);
        chk({tag, "_busy"}, 128'(bad_b), 128'd0);
        chk({tag, "_tt"}, c_tt, model_tt(m));
        chk({tag, "_onset"}, 128'(c_on), 128'(model_onset(m)));
    endtask

    // Hold off the consumer, optionally poke start, then accept the result
    task automatic handshake(input string tag, input int hold, input logic poke);
        logic [127:0] tt_s;
        logic [7:0]   on_s;
        int           bad = 0;
        tt_s = c_tt;
        on_s = c_on;
        ready_g = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start_g = poke && (h == hold / 2);
            tick();
            start_g = 1'b0;
            if (c_valid !== 1'b1 || c_busy !== 1'b0 || c_tt !== tt_s || c_on !== on_s) bad++;
        end
        chk({tag, "_hold"}, 128'(bad), 128'd0);
        ready_g = 1'b1;
        start_g = poke;
        tick();
        ready_g = 1'b0;
        start_g = 1'b0;
        chk({tag, "_valid_drop"}, 128'(c_valid), 128'd0);
        tick();
        chk({tag, "_idle_busy"}, 128'(c_busy), 128'd0);
        chk({tag, "_idle_tt"}, c_tt, tt_s);
    endtask

    initial begin
        int w;
        // Reset state
        #2;
        chk("rst_x", 128'(x1), 128'd0);
        chk("rst_tt", tt1, 128'd0);
        chk("rst_onset", 128'(on1), 128'd0);
        chk("rst_busy", 128'(busy1), 128'd0);
        chk("rst_valid", 128'({valid1, valid3}), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Constant zero
        sel = 0;
        run_sweep("zero", 1, 0);
        chk("zero_tt_const", tt1, 128'h0);
        handshake("zero", 0, 1'b0);

        // f = x0, with backpressure and ignored start pokes
        run_sweep("x0", 1, 1);
        chk("x0_tt_const", tt1, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
        handshake("x0_bp", 20, 1'b1);

        // Majority-network truth table, started back to back
        run_sweep("maj", 1, 2);
        handshake("maj", 3, 1'b0);

        // Constant one with SETTLE=3
        sel = 1;
        run_sweep("one_s3", 3, 3);
        chk("one_tt_const", tt3, {128{1'b1}});
        handshake("one_s3", 5, 1'b1);

        // Random truth table with random backpressure
        sel = 0;
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_sweep("rand", 1, 5);
        handshake("rand", int'($urandom_range(1, 10)), 1'b1);

        // Asynchronous reset in the middle of a sweep
        mode    = 4;
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        w = 0;
        while (x1 !== 7'd50 && w < 500) begin
            tick();
            w++;
        end
        chk("mid_reach50", 128'(x1), 128'd50);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_x", 128'(x1), 128'd0);
        chk("mid_rst_busy", 128'(busy1), 128'd0);
        chk("mid_rst_result", {tt1[119:0], on1}, 128'd0);
        chk("mid_rst_valid", 128'(valid1), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mid_after_valid", 128'(valid1), 128'd0);
        run_sweep("x6", 1, 4);
        chk("x6_tt_const", tt1, 128'hffffffffffffffff0000000000000000);
        handshake("x6", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
